// File: rtl/edge_detect_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Edge modes select which filtered transitions count as events.
package edge_detect_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_t;

    function automatic logic mode_hit(edge_mode_t m, logic rise, logic fall);
        return (rise && (m == EDGE_RISE || m == EDGE_BOTH)) ||
               (fall && (m == EDGE_FALL || m == EDGE_BOTH));
    endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One channel: synchroniser, debounce filter, edge pulses, mode-qualified
// event, sticky flag and saturating event counter.
module edge_detect_chan
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_i,
    input  edge_mode_t       mode_i,
    input  logic             clear_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             event_o,
    output logic             sticky_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_q, db_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d, fall_q, fall_d, event_q, event_d;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        db_d     = db_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        sticky_d = sticky_q;
        count_d  = count_q;
        if (sync_lvl == level_q) begin
            db_d = '0;
        end else if (db_q == DB_LAST) begin
            level_d = sync_lvl;
            db_d    = '0;
            rise_d  = sync_lvl;
            fall_d  = ~sync_lvl;
        end else begin
            db_d = db_q + 1'b1;
        end
        event_d = mode_hit(mode_i, rise_d, fall_d);
        // An event in the same cycle as a clear restarts the count at one.
        if (event_d) begin
            sticky_d = 1'b1;
            if (clear_i)
                count_d = CNT_W'(1);
            else if (count_q != '1)
                count_d = count_q + 1'b1;
        end else if (clear_i) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            db_q     <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            event_q  <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], a_i};
            db_q     <= db_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            event_q  <= event_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign event_o  = event_q;
    assign sticky_o = sticky_q;
    assign count_o  = count_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronising, debouncing edge detector with per-channel
// edge modes, sticky flags and saturating event counters.
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       a_i,
    input  logic [2*NUM_CH-1:0]     mode_i,
    input  logic [NUM_CH-1:0]       clear_i,
    output logic [NUM_CH-1:0]       level_o,
    output logic [NUM_CH-1:0]       rising_edge_o,
    output logic [NUM_CH-1:0]       falling_edge_o,
    output logic [NUM_CH-1:0]       event_o,
    output logic [NUM_CH-1:0]       sticky_o,
    output logic [NUM_CH*CNT_W-1:0] count_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        edge_detect_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .a_i     (a_i[c]),
            .mode_i  (edge_mode_t'(mode_i[2*c +: 2])),
            .clear_i (clear_i[c]),
            .level_o (level_o[c]),
            .rise_o  (rising_edge_o[c]),
            .fall_o  (falling_edge_o[c]),
            .event_o (event_o[c]),
            .sticky_o(sticky_o[c]),
            .count_o (count_o[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: a window-based reference model checked
// every cycle against two instances (8-bit and 2-bit counters), plus literal pins.
module tb_edge_detect_multi;
    import edge_detect_pkg::*;

    localparam int NCH = 4;
    localparam int S   = 2;
    localparam int D   = 4;
    localparam int H   = S + D;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   a_i = '0;
    logic [2*NCH-1:0] mode_i = '0;
    logic [NCH-1:0]   clear_i = '0;

    logic [NCH-1:0]   lvl8, rise8, fall8, ev8, stk8;
    logic [NCH*8-1:0] cnt8;
    logic [NCH-1:0]   lvl2, rise2, fall2, ev2, stk2;
    logic [NCH*2-1:0] cnt2;

    int n_chk = 0;
    int n_pass = 0;
    int rise2_seen = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    edge_detect_multi #(.NUM_CH(NCH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .a_i(a_i), .mode_i(mode_i), .clear_i(clear_i),
        .level_o(lvl8), .rising_edge_o(rise8), .falling_edge_o(fall8),
        .event_o(ev8), .sticky_o(stk8), .count_o(cnt8));

    edge_detect_multi #(.NUM_CH(NCH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .a_i(a_i), .mode_i(mode_i), .clear_i(clear_i),
        .level_o(lvl2), .rising_edge_o(rise2), .falling_edge_o(fall2),
        .event_o(ev2), .sticky_o(stk2), .count_o(cnt2));

    // Reference model: keep a history of raw samples; the filtered level flips
    // once the D most recent post-synchroniser samples all disagree with it.
    logic [NCH-1:0][H-1:0] m_hist;
    logic [NCH-1:0]        m_level, m_rise, m_fall, m_ev, m_stk;
    int                    m_cnt [NCH];

    function automatic bit flips(logic [H-1:0] h, logic lvl);
        for (int j = 0; j < D; j++)
            if (h[S-1+j] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit wants(logic [1:0] m, bit rising);
        edge_mode_t em = edge_mode_t'(m);
        if (em == EDGE_BOTH) return 1'b1;
        return rising ? (em == EDGE_RISE) : (em == EDGE_FALL);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hist <= '0; m_level <= '0; m_rise <= '0; m_fall <= '0; m_ev <= '0; m_stk <= '0;
            for (int c = 0; c < NCH; c++) m_cnt[c] <= 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                m_hist[c] <= {m_hist[c][H-2:0], a_i[c]};
                if (flips(m_hist[c], m_level[c])) begin
                    m_level[c] <= ~m_level[c];
                    m_rise[c]  <= ~m_level[c];
                    m_fall[c]  <= m_level[c];
                    m_ev[c]    <= wants(mode_i[2*c +: 2], ~m_level[c]);
                end else begin
                    m_rise[c] <= 1'b0; m_fall[c] <= 1'b0; m_ev[c] <= 1'b0;
                end
                if (flips(m_hist[c], m_level[c]) && wants(mode_i[2*c +: 2], ~m_level[c])) begin
                    m_stk[c] <= 1'b1;
                    m_cnt[c] <= clear_i[c] ? 1 : m_cnt[c] + 1;
                end else if (clear_i[c]) begin
                    m_stk[c] <= 1'b0;
                    m_cnt[c] <= 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        logic [NCH*8-1:0] e8;
        logic [NCH*2-1:0] e2;
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                e8[c*8 +: 8] = 8'((m_cnt[c] > 255) ? 255 : m_cnt[c]);
                e2[c*2 +: 2] = 2'((m_cnt[c] > 3) ? 3 : m_cnt[c]);
            end
            chk("level", {28'd0, lvl8}, {28'd0, m_level});
            chk("rise", {28'd0, rise8}, {28'd0, m_rise});
            chk("fall", {28'd0, fall8}, {28'd0, m_fall});
            chk("event", {28'd0, ev8}, {28'd0, m_ev});
            chk("sticky", {28'd0, stk8}, {28'd0, m_stk});
            chk("count8", cnt8, e8);
            chk("w2_pulses", {16'd0, lvl2, rise2, fall2, ev2}, {16'd0, m_level, m_rise, m_fall, m_ev});
            chk("w2_count", {20'd0, stk2, cnt2}, {20'd0, m_stk, e2});
            if (rise8[2]) rise2_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] c8(input int c);
        return {24'd0, cnt8[c*8 +: 8]};
    endfunction

    function automatic logic [31:0] c2(input int c);
        return {30'd0, cnt2[c*2 +: 2]};
    endfunction

    initial begin
        int r0;
        mode_i[1:0] = 2'(EDGE_RISE);
        mode_i[3:2] = 2'(EDGE_BOTH);
        mode_i[5:4] = 2'(EDGE_FALL);
        mode_i[7:6] = 2'(EDGE_BOTH);
        step(3);
        chk("rst_level", {28'd0, lvl8}, 32'd0);
        chk("rst_count", cnt8, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        step(5);

        // 1: rising edge on ch0 appears exactly 5 edges after first sample
        a_i[0] = 1'b1;
        step(5);
        chk("t1_early", {31'd0, lvl8[0]}, 32'd0);
        step(1);
        chk("t1_pulses", {29'd0, lvl8[0], rise8[0], ev8[0]}, 32'd7);
        step(1);
        chk("t1_after", {29'd0, rise8[0], ev8[0], stk8[0]}, 32'd1);
        chk("t1_count", c8(0), 32'd1);

        // 2: 3-cycle glitch rejected, 4-cycle pulse accepted on ch1
        a_i[1] = 1'b1; step(3); a_i[1] = 1'b0; step(12);
        chk("t2_glitch", {31'd0, lvl8[1]}, 32'd0);
        chk("t2_glitch_cnt", c8(1), 32'd0);
        a_i[1] = 1'b1; step(4); a_i[1] = 1'b0; step(15);
        chk("t2_pulse_cnt", c8(1), 32'd2);

        // 3: ch2 falling-only, 10 filtered edges
        r0 = rise2_seen;
        for (int i = 0; i < 10; i++) begin
            a_i[2] = ~a_i[2];
            step(8);
        end
        chk("t3_count", c8(2), 32'd5);
        chk("t3_raw_rise", 32'(rise2_seen - r0), 32'd5);

        // 4: saturation on the 2-bit instance, clear, clear-vs-event
        for (int i = 0; i < 5; i++) begin
            a_i[3] = ~a_i[3];
            step(8);
        end
        chk("t4_sat2", c2(3), 32'd3);
        chk("t4_cnt8", c8(3), 32'd5);
        clear_i[3] = 1'b1; step(1); clear_i[3] = 1'b0; step(1);
        chk("t4_clear", {28'd0, stk8[3], stk2[3], cnt2[7:6]}, 32'd0);
        a_i[3] = 1'b0;
        step(5);
        clear_i[3] = 1'b1; step(1); clear_i[3] = 1'b0;
        chk("t4_coinc8", c8(3), 32'd1);
        chk("t4_coinc2", {30'd0, stk2[3], cnt2[7]}, 32'd2);

        // 5: reset mid-debounce, then full-latency rise with input held high
        a_i = '0; step(10);
        a_i[0] = 1'b1;
        step(4);
        #2 reset = 1'b1;
        #1 chk("t5_async", {cnt8, 4'd0, stk8}, 36'd0);
        step(2);
        reset = 1'b0;
        step(5);
        chk("t5_early", {31'd0, lvl8[0]}, 32'd0);
        step(1);
        chk("t5_rise", {29'd0, lvl8[0], rise8[0], ev8[0]}, 32'd7);

        // 6: all channels edge together with mixed modes
        mode_i[1:0] = 2'(EDGE_RISE);
        mode_i[3:2] = 2'(EDGE_FALL);
        mode_i[5:4] = 2'(EDGE_BOTH);
        mode_i[7:6] = 2'(EDGE_OFF);
        a_i = '0; step(10);
        clear_i = '1; step(1); clear_i = '0;
        a_i = '1; step(8);
        a_i = '0; step(8);
        chk("t6_counts", cnt8, {8'd0, 8'd2, 8'd1, 8'd1});
        chk("t6_sticky", {28'd0, stk8}, 32'h7);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
